// File: rtl/pipeline_stall_ctrl.sv
// ============================================================================
//  Module      : pipeline_stall_ctrl
//  Description : Stall/flush sequencer for the 5-stage pipeline. It merges the
//                load-use hazard, EX branch redirect, MDU occupancy and DRAM
//                wait into per-register stall/flush controls. Optional perf
//                counters are built only when PIPE_PERF_CNT_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipeline_stall_ctrl #(
    parameter int MDU_TIMEOUT = 64,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             data_hazard,
    input  logic             ex_br_taken,
    input  logic             ex_mdu_start,
    input  logic             mdu_done,
    input  logic             mem_wait,
    output logic             pc_stall,
    output logic             if_id_stall,
    output logic             if_id_flush,
    output logic             id_ex_stall,
    output logic             id_ex_flush,
    output logic             ex_mem_stall,
    output logic             ex_mem_flush,
    output logic             mem_wb_flush,
    output logic             mdu_timeout,
    output logic [CNT_W-1:0] perf_cycles,
    output logic [CNT_W-1:0] perf_stalls,
    output logic [CNT_W-1:0] perf_flushes
);

    localparam int          c_TMO_W    = (MDU_TIMEOUT > 2) ? $clog2(MDU_TIMEOUT) : 1;
    localparam logic [0:0]  c_RUN      = 1'b0;
    localparam logic [0:0]  c_MDU_WAIT = 1'b1;

    logic [0:0]         r_state;
    logic [0:0]         w_next_state;
    logic [c_TMO_W-1:0] r_tmo_cnt;
    logic               w_tmo_hit;

    logic w_pc_stall, w_if_id_stall, w_if_id_flush, w_id_ex_stall, w_id_ex_flush;
    logic w_ex_mem_stall, w_ex_mem_flush, w_mem_wb_flush, w_mdu_timeout;

    assign w_tmo_hit = (r_tmo_cnt == c_TMO_W'(MDU_TIMEOUT - 1));

    always_comb begin
        w_next_state   = r_state;
        w_pc_stall     = 1'b0;
        w_if_id_stall  = 1'b0;
        w_if_id_flush  = 1'b0;
        w_id_ex_stall  = 1'b0;
        w_id_ex_flush  = 1'b0;
        w_ex_mem_stall = 1'b0;
        w_ex_mem_flush = 1'b0;
        w_mem_wb_flush = 1'b0;
        w_mdu_timeout  = 1'b0;

        if (rst) begin
            w_next_state   = c_RUN;
            w_if_id_flush  = 1'b1;
            w_id_ex_flush  = 1'b1;
            w_ex_mem_flush = 1'b1;
            w_mem_wb_flush = 1'b1;
        end else if (mem_wait) begin
            w_pc_stall     = 1'b1;
            w_if_id_stall  = 1'b1;
            w_id_ex_stall  = 1'b1;
            w_ex_mem_stall = 1'b1;
            w_mem_wb_flush = 1'b1;
        end else if ((r_state == c_RUN && ex_mdu_start && !mdu_done) ||
                     (r_state == c_MDU_WAIT && !mdu_done && !w_tmo_hit)) begin
            // MDU occupies EX: freeze the front end, bubble into MEM
            w_next_state   = c_MDU_WAIT;
            w_pc_stall     = 1'b1;
            w_if_id_stall  = 1'b1;
            w_id_ex_stall  = 1'b1;
            w_ex_mem_flush = 1'b1;
        end else if (r_state == c_MDU_WAIT && !mdu_done) begin
            w_next_state  = c_RUN;
            w_mdu_timeout = 1'b1;
        end else begin
            // RUN, or MDU completion letting the resumed EX instruction act
            w_next_state = c_RUN;
            if (ex_br_taken) begin
                w_if_id_flush = 1'b1;
                w_id_ex_flush = 1'b1;
            end else if (data_hazard) begin
                w_pc_stall    = 1'b1;
                w_if_id_stall = 1'b1;
                w_id_ex_flush = 1'b1;
            end
        end
    end

    assign pc_stall     = w_pc_stall;
    assign if_id_stall  = w_if_id_stall;
    assign if_id_flush  = w_if_id_flush & ~w_if_id_stall;
    assign id_ex_stall  = w_id_ex_stall;
    assign id_ex_flush  = w_id_ex_flush & ~w_id_ex_stall;
    assign ex_mem_stall = w_ex_mem_stall;
    assign ex_mem_flush = w_ex_mem_flush & ~w_ex_mem_stall;
    assign mem_wb_flush = w_mem_wb_flush;
    assign mdu_timeout  = w_mdu_timeout;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= c_RUN;
            r_tmo_cnt <= '0;
        end else begin
            r_state <= w_next_state;
            if (!mem_wait) begin
                if (r_state == c_RUN)
                    r_tmo_cnt <= '0;
                else
                    r_tmo_cnt <= r_tmo_cnt + c_TMO_W'(1);
            end
        end
    end

`ifdef PIPE_PERF_CNT_EN
    logic [CNT_W-1:0] r_perf_cycles;
    logic [CNT_W-1:0] r_perf_stalls;
    logic [CNT_W-1:0] r_perf_flushes;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_perf_cycles  <= '0;
            r_perf_stalls  <= '0;
            r_perf_flushes <= '0;
        end else begin
            r_perf_cycles <= r_perf_cycles + CNT_W'(1);
            if (pc_stall)
                r_perf_stalls <= r_perf_stalls + CNT_W'(1);
            if (if_id_flush)
                r_perf_flushes <= r_perf_flushes + CNT_W'(1);
        end
    end

    assign perf_cycles  = r_perf_cycles;
    assign perf_stalls  = r_perf_stalls;
    assign perf_flushes = r_perf_flushes;
`else
    assign perf_cycles  = '0;
    assign perf_stalls  = '0;
    assign perf_flushes = '0;
`endif

endmodule

`default_nettype wire
